subpel_sad_select: RTL and testbench



---
 rtl/subpel_sad_select_pkg.sv | 65 ++++++
 rtl/subpel_sad_select_sum7.sv | 22 ++
 rtl/subpel_sad_select.sv | 166 ++++++++++++++++
 tb/tb_subpel_sad_select.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/subpel_sad_select_pkg.sv
// Shared constants, FSM encoding and candidate index helpers for subpel_sad_select.
package subpel_sad_select_pkg;

  localparam int unsigned NUM_CAND   = 25;
  localparam int unsigned CENTER_IDX = 12;
  localparam int unsigned NUM_VPOS   = 5;
  localparam int unsigned NUM_HPOS   = 5;
  localparam int unsigned IDX_W      = 5;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned LINE_W     = 56;
  localparam int unsigned HQ_W       = 112;
  localparam int unsigned F_W        = 56;
  localparam int unsigned SUM_W      = 11;
  localparam int unsigned COST_PAD   = 4;

  // Vertical ordering on every diff bus, LSB first.
  localparam int unsigned VPOS_UH = 0;
  localparam int unsigned VPOS_UQ = 1;
  localparam int unsigned VPOS_M  = 2;
  localparam int unsigned VPOS_LQ = 3;
  localparam int unsigned VPOS_LH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic int unsigned hq_off(input int unsigned v);
    return v * HQ_W;
  endfunction

  function automatic int unsigned f_off(input int unsigned v);
    return v * F_W;
  endfunction

  // Scan order visits the center first so ties resolve toward it.
  function automatic logic [IDX_W-1:0] scan_to_idx(input logic [CNT_W-1:0] cnt);
    if (cnt == '0) return IDX_W'(CENTER_IDX);
    else if (cnt <= CNT_W'(CENTER_IDX)) return cnt - IDX_W'(1);
    else return cnt;
  endfunction

  function automatic logic [2:0] idx_dx(input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] r;
    r = idx % IDX_W'(NUM_HPOS);
    return 3'(r) - 3'd2;
  endfunction

  function automatic logic [2:0] idx_dy(input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] r;
    r = idx / IDX_W'(NUM_HPOS);
    return 3'(r) - 3'd2;
  endfunction

  function automatic logic [2:0] abs3(input logic [2:0] v);
    return v[2] ? 3'd0 - v : v;
  endfunction

  function automatic logic [2:0] mv_abs_sum(input logic [IDX_W-1:0] idx);
    return abs3(idx_dx(idx)) + abs3(idx_dy(idx));
  endfunction

endpackage

// File: rtl/subpel_sad_select_sum7.sv
// sad_line_sum7: combinational sum of seven unsigned bytes into an 11-bit line sum.
module sad_line_sum7
  import subpel_sad_select_pkg::*;
(
  input  logic [LINE_W-1:0] line,
  output logic [SUM_W-1:0]  sum_c
);

  logic [8:0] s01;
  logic [8:0] s23;
  logic [8:0] s45;
  logic [9:0] s0123;
  logic [9:0] s456;

  assign s01   = 9'(line[7:0])   + 9'(line[15:8]);
  assign s23   = 9'(line[23:16]) + 9'(line[31:24]);
  assign s45   = 9'(line[39:32]) + 9'(line[47:40]);
  assign s0123 = 10'(s01) + 10'(s23);
  assign s456  = 10'(s45) + 10'(line[55:48]);
  assign sum_c = 11'(s0123) + 11'(s456);

endmodule

// File: rtl/subpel_sad_select.sv
// Accumulates 25 sub-pel candidate SADs per block and scans for the best vector.
// Optional build macro SUBPEL_MV_COST_EN adds LAMBDA*(|dx|+|dy|) to the compare key.
module subpel_sad_select
  import subpel_sad_select_pkg::*;
#(
  parameter int unsigned SAD_W  = 16,
  parameter int unsigned LAMBDA = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [5*HQ_W-1:0]     diff_h_bus,
  input  logic [5*HQ_W-1:0]     diff_q_bus,
  input  logic [5*F_W-1:0]      diff_f_bus,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2:0]            best_dx,
  output logic [2:0]            best_dy,
  output logic [SAD_W-1:0]      best_sad
);

  localparam int unsigned KEY_W = SAD_W + COST_PAD;
  localparam int unsigned EXT_W = SAD_W + 1;
  localparam logic [SAD_W-1:0] SAD_MAX = '1;

  state_e               state;
  logic [CNT_W-1:0]     scan_cnt;
  logic                 beat_acc_c;
  logic [SUM_W-1:0]     line_sum_c [NUM_CAND];
  logic [SAD_W-1:0]     acc_rd     [NUM_CAND];
  logic [IDX_W-1:0]     scan_idx_c;
  logic [KEY_W-1:0]     cand_key_c;

  logic                 pipe_vld;
  logic                 pipe_first;
  logic [KEY_W-1:0]     pipe_key;
  logic [SAD_W-1:0]     pipe_sad;
  logic [2:0]           pipe_dx;
  logic [2:0]           pipe_dy;
  logic [KEY_W-1:0]     best_key;

  assign beat_acc_c = in_valid & in_ready;

  // Per-candidate line slicing, line sum and saturating accumulator.
  for (genvar v = 0; v < NUM_VPOS; v++) begin : g_vpos
    for (genvar hp = 0; hp < NUM_HPOS; hp++) begin : g_hpos
      localparam int unsigned IDX = v * NUM_HPOS + hp;
      logic [LINE_W-1:0] line_c;
      logic [EXT_W-1:0]  acc_nxt_c;
      logic [SAD_W-1:0]  acc_q;

      if (hp == 0) begin : g_hm
        assign line_c = diff_h_bus[hq_off(v) +: LINE_W];
      end else if (hp == 1) begin : g_qm
        assign line_c = diff_q_bus[hq_off(v) +: LINE_W];
      end else if (hp == 2) begin : g_f
        assign line_c = diff_f_bus[f_off(v) +: LINE_W];
      end else if (hp == 3) begin : g_qp
        assign line_c = diff_q_bus[hq_off(v) + LINE_W +: LINE_W];
      end else begin : g_hp
        assign line_c = diff_h_bus[hq_off(v) + LINE_W +: LINE_W];
      end

      sad_line_sum7 u_sum (
        .line  (line_c),
        .sum_c (line_sum_c[IDX])
      );

      // The first beat of a block starts from zero rather than the stale total.
      assign acc_nxt_c = ((state == ST_IDLE) ? '0 : EXT_W'(acc_q)) + EXT_W'(line_sum_c[IDX]);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc_q <= '0;
        end else if (beat_acc_c) begin
          acc_q <= acc_nxt_c[SAD_W] ? SAD_MAX : acc_nxt_c[SAD_W-1:0];
        end
      end

      assign acc_rd[IDX] = acc_q;
    end
  end

  assign scan_idx_c = scan_to_idx(scan_cnt);

`ifdef SUBPEL_MV_COST_EN
  assign cand_key_c = KEY_W'(acc_rd[scan_idx_c])
                    + KEY_W'(LAMBDA) * KEY_W'(mv_abs_sum(scan_idx_c));
`else
  logic unused_lambda;
  assign unused_lambda = |32'(LAMBDA);
  assign cand_key_c    = KEY_W'(acc_rd[scan_idx_c]);
`endif

  // Control FSM; the scan registers one candidate per cycle into a compare stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      scan_cnt   <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      pipe_vld   <= 1'b0;
      pipe_first <= 1'b0;
      pipe_key   <= '0;
      pipe_sad   <= '0;
      pipe_dx    <= '0;
      pipe_dy    <= '0;
    end else begin
      pipe_vld <= 1'b0;
      case (state)
        ST_IDLE, ST_ACC: begin
          if (beat_acc_c) begin
            state    <= in_last ? ST_SCAN : ST_ACC;
            in_ready <= ~in_last;
            scan_cnt <= '0;
          end
        end
        ST_SCAN: begin
          if (scan_cnt < CNT_W'(NUM_CAND)) begin
            pipe_vld   <= 1'b1;
            pipe_first <= (scan_cnt == '0);
            pipe_key   <= cand_key_c;
            pipe_sad   <= acc_rd[scan_idx_c];
            pipe_dx    <= idx_dx(scan_idx_c);
            pipe_dy    <= idx_dy(scan_idx_c);
            scan_cnt   <= scan_cnt + CNT_W'(1);
          end else begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            scan_cnt  <= '0;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Strict less-than keeps the earlier candidate on ties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_key <= '0;
      best_sad <= '0;
      best_dx  <= '0;
      best_dy  <= '0;
    end else if (pipe_vld && (pipe_first || (pipe_key < best_key))) begin
      best_key <= pipe_key;
      best_sad <= pipe_sad;
      best_dx  <= pipe_dx;
      best_dy  <= pipe_dy;
    end
  end

endmodule

// File: tb/tb_subpel_sad_select.sv
// Directed bench for subpel_sad_select (SAD_W=12, LAMBDA=4).
module tb_subpel_sad_select;

  localparam int unsigned SAD_W  = 12;
  localparam int unsigned LAMBDA = 4;

  localparam logic [2:0] D_M2 = 3'b110;
  localparam logic [2:0] D_M1 = 3'b111;
  localparam logic [2:0] D_0  = 3'b000;
  localparam logic [2:0] D_P1 = 3'b001;
  localparam logic [2:0] D_P2 = 3'b010;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic [559:0]     diff_h_bus;
  logic [559:0]     diff_q_bus;
  logic [279:0]     diff_f_bus;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       best_dx;
  logic [2:0]       best_dy;
  logic [SAD_W-1:0] best_sad;

  logic [7:0] cby [5][5][7];
  int vectors    = 0;
  int miscompares = 0;

  subpel_sad_select #(.SAD_W(SAD_W), .LAMBDA(LAMBDA)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .diff_h_bus (diff_h_bus),
    .diff_q_bus (diff_q_bus),
    .diff_f_bus (diff_f_bus),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .best_dx    (best_dx),
    .best_dy    (best_dy),
    .best_sad   (best_sad)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill_all(input logic [7:0] val);
    for (int v = 0; v < 5; v++)
      for (int hp = 0; hp < 5; hp++)
        for (int k = 0; k < 7; k++) cby[v][hp][k] = val;
  endtask

  task automatic set_cand(input int v, input int hp, input logic [7:0] val);
    for (int k = 0; k < 7; k++) cby[v][hp][k] = val;
  endtask

  task automatic pack();
    logic [55:0] ln;
    for (int v = 0; v < 5; v++) begin
      for (int hp = 0; hp < 5; hp++) begin
        for (int k = 0; k < 7; k++) ln[k*8 +: 8] = cby[v][hp][k];
        case (hp)
          0: diff_h_bus[v*112 +: 56]      = ln;
          1: diff_q_bus[v*112 +: 56]      = ln;
          2: diff_f_bus[v*56 +: 56]       = ln;
          3: diff_q_bus[v*112 + 56 +: 56] = ln;
          default: diff_h_bus[v*112 + 56 +: 56] = ln;
        endcase
      end
    end
  endtask

  // Called #1 after a posedge; returns #1 after the posedge accepting the last beat.
  task automatic send_block(input string tag, input int nbeats);
    pack();
    for (int b = 0; b < nbeats; b++) begin
      chk({tag, "_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_last  = (b == nbeats - 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic check_result(input string tag, input logic [2:0] dx, input logic [2:0] dy,
                              input logic [SAD_W-1:0] sad);
    int cyc;
    wait_out(cyc);
    chk({tag, "_latency"}, 32'(cyc), 32'd26);
    chk({tag, "_dx"}, 32'(best_dx), 32'(dx));
    chk({tag, "_dy"}, 32'(best_dy), 32'(dy));
    chk({tag, "_sad"}, 32'(best_sad), 32'(sad));
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_ovld_low"}, 32'(out_valid), 32'd0);
    chk({tag, "_rdy_high"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    out_ready  = 1'b0;
    diff_h_bus = '0;
    diff_q_bus = '0;
    diff_f_bus = '0;
    fill_all(8'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    chk("rst_ovld", 32'(out_valid), 32'd0);
    chk("rst_rdy",  32'(in_ready),  32'd1);
    chk("rst_dx",   32'(best_dx),   32'(D_0));
    chk("rst_dy",   32'(best_dy),   32'(D_0));
    chk("rst_sad",  32'(best_sad),  32'd0);

    // All ones over 8 lines: every SAD is 56, the center wins the tie.
    fill_all(8'd1);
    send_block("t1", 8);
    check_result("t1", D_0, D_0, 12'd56);
    handshake("t1");

    // UQ +quarter has the smallest SAD: 2*7*4 = 56; center 140; others 252.
    fill_all(8'd9);
    set_cand(2, 2, 8'd5);
    set_cand(1, 3, 8'd2);
    send_block("t2", 4);
    check_result("t2", D_P1, D_M1, 12'd56);

    // Stall in DONE with in_valid asserted: nothing is consumed, outputs hold.
    fill_all(8'd0);
    pack();
    in_valid = 1'b1;
    in_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("stall_ovld", 32'(out_valid), 32'd1);
      chk("stall_rdy",  32'(in_ready),  32'd0);
      chk("stall_sad",  32'(best_sad),  32'd56);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    handshake("t2");

    // Fresh single-beat block after the stall: no carry-over from earlier sums.
    fill_all(8'd1);
    send_block("t2b", 1);
    check_result("t2b", D_0, D_0, 12'd7);
    handshake("t2b");

    // 0xFF over 3 lines overflows 12 bits; everything clamps at 4095.
    fill_all(8'hFF);
    send_block("t3", 3);
    check_result("t3", D_0, D_0, 12'd4095);
    handshake("t3");

    // Reset in the middle of the scan.
    fill_all(8'd2);
    send_block("t4", 1);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk("t4_rst_ovld", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_rel_ovld", 32'(out_valid), 32'd0);
    chk("t4_rel_rdy",  32'(in_ready),  32'd1);
    chk("t4_rel_sad",  32'(best_sad),  32'd0);
    chk("t4_rel_dx",   32'(best_dx),   32'(D_0));

    // LH -half with zero diffs wins outright after the reset.
    fill_all(8'd3);
    set_cand(4, 0, 8'd0);
    send_block("t5", 1);
    check_result("t5", D_M2, D_P2, 12'd0);
    handshake("t5");

    // Center 40 vs UQ +quarter 35 (cost 43 with LAMBDA=4); others 63.
    fill_all(8'd9);
    set_cand(2, 2, 8'd5);
    cby[2][2][0] = 8'd10;
    set_cand(1, 3, 8'd5);
    send_block("t6", 1);
`ifdef SUBPEL_MV_COST_EN
    check_result("t6", D_0, D_0, 12'd40);
`else
    check_result("t6", D_P1, D_M1, 12'd35);
`endif
    handshake("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
